fila_instrucoes_param: RTL and testbench

- Parametrised instruction queue sitting between the instruction memory and the dispatch/issue stage.
- Autonomously fetches sequential instructions from a 1-cycle-latency synchronous instruction memory into a circular buffer.
- Presents the oldest entry to dispatch with show-ahead semantics.
- Adds over the previous generation:
  - configurable width and depth,
  - fetch throttling with in-flight tracking,
  - a fetch stall input,
  - flush with PC redirect for branches.

---
 rtl/fila_instrucoes_param.sv | 104 ++++++++++
 tb/tb_fila_instrucoes_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fila_instrucoes_param.sv
// Instruction queue: sequential prefetch into a circular buffer, show-ahead head.
// Optional FILA_STATS_EN adds fetch/dispatch counters and a sticky overflow flag.
module fila_instrucoes_param #(
  parameter int INSTR_W = 16,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Flush,
  input  logic [ADDR_W-1:0]  Flush_PC,
  input  logic               Stall_Fetch,
  output logic               Fetch_Req,
  output logic [ADDR_W-1:0]  Fetch_Addr,
  input  logic [INSTR_W-1:0] Fetch_Data,
  input  logic               Pop,
  output logic [INSTR_W-1:0] Instr_Out,
  output logic               Instr_Valid,
  output logic               Full,
  output logic               Empty,
  output logic [$clog2(DEPTH):0] Count
`ifdef FILA_STATS_EN
  ,
  output logic [31:0]        Fetched_Cnt,
  output logic [31:0]        Dispatched_Cnt,
  output logic               Overflow_Err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  pc;
  logic               pend;
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [CW-1:0]      count;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic               push;
  logic               pop_ok;

  assign Empty       = (count == '0);
  assign Full        = (count == CW'(DEPTH));
  assign Count       = count;
  assign Instr_Valid = ~Empty;
  assign Instr_Out   = Empty ? '0 : mem[head];
  assign Fetch_Addr  = pc;

  // Pending response reserves a slot so it can never be dropped.
  assign Fetch_Req = ~Reset & ~Flush & ~Stall_Fetch &
                     ((count + CW'(pend)) < CW'(DEPTH));

  assign push   = pend & ~Flush;
  assign pop_ok = Pop & ~Empty & ~Flush;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc    <= RESET_PC;
      pend  <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (Flush) begin
      pc    <= Flush_PC;
      pend  <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      pend <= Fetch_Req;
      if (Fetch_Req) pc <= pc + ADDR_W'(1);
      if (push) tail <= tail + PW'(1);
      if (pop_ok) head <= head + PW'(1);
      unique case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem[tail] <= Fetch_Data;
  end

`ifdef FILA_STATS_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Fetched_Cnt    <= '0;
      Dispatched_Cnt <= '0;
      Overflow_Err   <= 1'b0;
    end else begin
      if (push && Fetched_Cnt != '1)
        Fetched_Cnt <= Fetched_Cnt + 32'd1;
      if (pop_ok && Dispatched_Cnt != '1)
        Dispatched_Cnt <= Dispatched_Cnt + 32'd1;
      if (push && Full)
        Overflow_Err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fila_instrucoes_param.sv
// Directed bench for fila_instrucoes_param against a 1-cycle memory model.
// Memory word at address a is 16'h1000 + a.
module tb_fila_instrucoes_param;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic [7:0]  Flush_PC = 8'h00;
  logic        Stall_Fetch = 1'b0;
  logic        Fetch_Req;
  logic [7:0]  Fetch_Addr;
  logic [15:0] Fetch_Data = 16'h0000;
  logic        Pop = 1'b0;
  logic [15:0] Instr_Out;
  logic        Instr_Valid;
  logic        Full;
  logic        Empty;
  logic [4:0]  Count;
`ifdef FILA_STATS_EN
  logic [31:0] Fetched_Cnt;
  logic [31:0] Dispatched_Cnt;
  logic        Overflow_Err;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  fila_instrucoes_param dut (
    .Clock(Clock),
    .Reset(Reset),
    .Flush(Flush),
    .Flush_PC(Flush_PC),
    .Stall_Fetch(Stall_Fetch),
    .Fetch_Req(Fetch_Req),
    .Fetch_Addr(Fetch_Addr),
    .Fetch_Data(Fetch_Data),
    .Pop(Pop),
    .Instr_Out(Instr_Out),
    .Instr_Valid(Instr_Valid),
    .Full(Full),
    .Empty(Empty),
    .Count(Count)
`ifdef FILA_STATS_EN
    ,
    .Fetched_Cnt(Fetched_Cnt),
    .Dispatched_Cnt(Dispatched_Cnt),
    .Overflow_Err(Overflow_Err)
`endif
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (Fetch_Req) Fetch_Data <= 16'h1000 + {8'h00, Fetch_Addr};
  end

  always @(negedge Clock) begin
    checks++;
    assert (Count <= 5'd16) else begin
      errors++;
      $error("FAIL overflow: count=%0d limit=16", Count);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #2;
    check("rst_empty", 32'(Empty), 1);
    check("rst_full", 32'(Full), 0);
    check("rst_valid", 32'(Instr_Valid), 0);
    check("rst_req", 32'(Fetch_Req), 0);
    check("rst_out", 32'(Instr_Out), 0);
    check("rst_count", 32'(Count), 0);
    step();
    Reset = 1'b0;
    #1;

    // Fill from empty with no pops
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (Fetch_Req) begin
        check("fill_addr", 32'(Fetch_Addr), 32'(n));
        n++;
      end
      step();
    end
    check("fill_pulses", 32'(n), 16);
    check("fill_full", 32'(Full), 1);
    check("fill_count", 32'(Count), 16);
    check("fill_req", 32'(Fetch_Req), 0);
    check("fill_out", 32'(Instr_Out), 32'h1000);

    // Continuous drain from full
    Pop = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      check("drain_valid", 32'(Instr_Valid), 1);
      check("drain_out", 32'(Instr_Out), 32'h1000 + 32'(i));
      step();
    end
    Pop = 1'b0;
    #1;

    // Flush with a response in flight
    Flush = 1'b1;
    Flush_PC = 8'h00;
    step();
    Flush = 1'b0;
    #1;
    check("fl0_empty", 32'(Empty), 1);
    check("fl0_addr", 32'(Fetch_Addr), 0);
    repeat (6) step();
    check("fl_count5", 32'(Count), 5);
    Flush = 1'b1;
    Flush_PC = 8'h40;
    #1;
    check("fl_req_blk", 32'(Fetch_Req), 0);
    step();
    Flush = 1'b0;
    #1;
    check("fl_empty", 32'(Empty), 1);
    check("fl_count", 32'(Count), 0);
    check("fl_req", 32'(Fetch_Req), 1);
    check("fl_addr", 32'(Fetch_Addr), 32'h40);
    step();
    check("fl_lat_empty", 32'(Empty), 1);
    step();
    check("fl_first", 32'(Instr_Out), 32'h1040);
    check("fl_first_cnt", 32'(Count), 1);

    // Stall right after a request
    Stall_Fetch = 1'b1;
    #1;
    check("st_req0", 32'(Fetch_Req), 0);
    step();
    check("st_cnt_a", 32'(Count), 2);
    check("st_req1", 32'(Fetch_Req), 0);
    step();
    check("st_cnt_b", 32'(Count), 2);
    Pop = 1'b1;
    #1;
    step();
    check("st_pop_cnt", 32'(Count), 1);
    check("st_pop_out", 32'(Instr_Out), 32'h1041);
    step();
    check("st_drained", 32'(Empty), 1);
    check("st_out0", 32'(Instr_Out), 0);
    step();
    check("st_cnt0", 32'(Count), 0);
    check("st_req2", 32'(Fetch_Req), 0);
    Stall_Fetch = 1'b0;
    Pop = 1'b0;
    #1;
    check("st_resume", 32'(Fetch_Req), 1);
    check("st_res_addr", 32'(Fetch_Addr), 32'h42);

    // Reset mid-stream, then pop on empty
    repeat (8) step();
    check("mr_count7", 32'(Count), 7);
    Reset = 1'b1;
    #1;
    check("mr_empty", 32'(Empty), 1);
    check("mr_req", 32'(Fetch_Req), 0);
    check("mr_count", 32'(Count), 0);
    check("mr_valid", 32'(Instr_Valid), 0);
    step();
    Stall_Fetch = 1'b1;
    Pop = 1'b1;
    Reset = 1'b0;
    #1;
    check("pe_req", 32'(Fetch_Req), 0);
    step();
    check("pe_count", 32'(Count), 0);
    check("pe_empty", 32'(Empty), 1);
    check("pe_out", 32'(Instr_Out), 0);
`ifdef FILA_STATS_EN
    check("pe_disp", Dispatched_Cnt, 0);
`endif
    Stall_Fetch = 1'b0;
    Pop = 1'b0;
    #1;
    check("mr_req1", 32'(Fetch_Req), 1);
    check("mr_addr", 32'(Fetch_Addr), 0);
    step();
    step();
    check("mr_first", 32'(Instr_Out), 32'h1000);
    check("mr_cnt1", 32'(Count), 1);

    // PC wrap 0xFF -> 0x00
    Flush = 1'b1;
    Flush_PC = 8'hFE;
    step();
    Flush = 1'b0;
    #1;
    check("wr_fe", 32'(Fetch_Addr), 32'hFE);
    step();
    check("wr_ff", 32'(Fetch_Addr), 32'hFF);
    step();
    check("wr_00", 32'(Fetch_Addr), 0);
    check("wr_out0", 32'(Instr_Out), 32'h10FE);
    step();
    check("wr_hold", 32'(Instr_Out), 32'h10FE);
    check("wr_cnt", 32'(Count), 2);
    Pop = 1'b1;
    #1;
    step();
    check("wr_out1", 32'(Instr_Out), 32'h10FF);
    step();
    check("wr_out2", 32'(Instr_Out), 32'h1000);
    Pop = 1'b0;
`ifdef FILA_STATS_EN
    check("ovf_err", 32'(Overflow_Err), 0);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
